// File: rtl/shift_writeback_pkg.sv
// Shared definitions for the shift unit and its writeback stage:
// shift-code constants and the occupancy state encoding.
package shift_writeback_pkg;

    localparam logic [1:0] CODE_DIRECT  = 2'b00;
    localparam logic [1:0] CODE_RIGHT   = 2'b01;
    localparam logic [1:0] CODE_LEFT    = 2'b10;
    localparam logic [1:0] CODE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } occState_e;

    function automatic logic isIllegal(input logic [1:0] code);
        return (code == CODE_ILLEGAL);
    endfunction

endpackage

// File: rtl/shift_writeback_if.sv
// Bus between the shift unit, the writeback stage and the register-file write port.
interface shift_writeback_if #(
    parameter int size  = 8,
    parameter int ADDRW = 3
);
    logic [size-1:0]  shiftIn;
    logic [1:0]       codeIn;
    logic [ADDRW-1:0] destIn;
    logic             validIn;
    logic             readyOut;
    logic             wbStall;
    logic             regWrEn;
    logic [ADDRW-1:0] regWrAddr;
    logic [size-1:0]  regWrData;

    modport master (
        output shiftIn, codeIn, destIn, validIn, wbStall,
        input  readyOut, regWrEn, regWrAddr, regWrData
    );

    modport slave (
        input  shiftIn, codeIn, destIn, validIn, wbStall,
        output readyOut, regWrEn, regWrAddr, regWrData
    );
endinterface

// File: rtl/shift_writeback_wb_fifo2.sv
// Two-entry FIFO whose occupancy is tracked by an EMPTY/ONE/FULL state machine;
// pointers are single bits so they wrap modulo 2 by construction.
module wb_fifo2
    import shift_writeback_pkg::*;
#(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wrData,
    output logic [W-1:0] rdData,
    output logic         full,
    output logic         empty
);
    occState_e    state_r;
    logic         wrPtr_r;
    logic         rdPtr_r;
    logic [W-1:0] mem_r [2];
    logic         pushOk_s;
    logic         popOk_s;

    assign pushOk_s = push && (state_r != ST_FULL);
    assign popOk_s  = pop  && (state_r != ST_EMPTY);
    assign full     = (state_r == ST_FULL);
    assign empty    = (state_r == ST_EMPTY);
    assign rdData   = mem_r[rdPtr_r];

    // Occupancy state, pointers and storage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_EMPTY;
            wrPtr_r  <= 1'b0;
            rdPtr_r  <= 1'b0;
            mem_r[0] <= '0;
            mem_r[1] <= '0;
        end else begin
            if (pushOk_s) begin
                mem_r[wrPtr_r] <= wrData;
                wrPtr_r        <= ~wrPtr_r;
            end
            if (popOk_s) begin
                rdPtr_r <= ~rdPtr_r;
            end
            case (state_r)
                ST_EMPTY: state_r <= pushOk_s ? ST_ONE : ST_EMPTY;
                ST_ONE: begin
                    if (pushOk_s && !popOk_s) begin
                        state_r <= ST_FULL;
                    end else if (popOk_s && !pushOk_s) begin
                        state_r <= ST_EMPTY;
                    end else begin
                        state_r <= ST_ONE;
                    end
                end
                ST_FULL:  state_r <= popOk_s ? ST_ONE : ST_FULL;
                default:  state_r <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/shift_writeback.sv
// Writeback stage: buffers shift-unit results and issues one register-file write
// per popped legal entry, tracking zero/negative/illegal status flags.
module shift_writeback
    import shift_writeback_pkg::*;
#(
    parameter int size  = 8,
    parameter int ADDRW = 3
) (
    input  logic               clk,
    input  logic               rst,
    shift_writeback_if.slave   bus,
    output logic               flagZero,
    output logic               flagNeg,
    output logic               flagIllegal,
    output logic               busy
);
    localparam int ENTRYW = size + 2 + ADDRW;

    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic [ENTRYW-1:0] headEntry_s;
    logic [size-1:0]   headData_s;
    logic [1:0]        headCode_s;
    logic [ADDRW-1:0]  headDest_s;
    logic              regWrEn_r;
    logic [ADDRW-1:0]  regWrAddr_r;
    logic [size-1:0]   regWrData_r;

    assign bus.readyOut = !full_s;
    assign busy         = !empty_s;
    assign push_s       = bus.validIn && !full_s;
    assign pop_s        = !empty_s && !bus.wbStall;
    assign {headData_s, headCode_s, headDest_s} = headEntry_s;

    wb_fifo2 #(.W(ENTRYW)) uFifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push_s),
        .pop    (pop_s),
        .wrData ({bus.shiftIn, bus.codeIn, bus.destIn}),
        .rdData (headEntry_s),
        .full   (full_s),
        .empty  (empty_s)
    );

    // Write strobe is a one-cycle pulse; address/data/flags hold between writes
    always_ff @(posedge clk) begin
        if (rst) begin
            regWrEn_r   <= 1'b0;
            regWrAddr_r <= '0;
            regWrData_r <= '0;
            flagZero    <= 1'b0;
            flagNeg     <= 1'b0;
            flagIllegal <= 1'b0;
        end else begin
            regWrEn_r <= 1'b0;
            if (pop_s && !isIllegal(headCode_s)) begin
                regWrEn_r   <= 1'b1;
                regWrAddr_r <= headDest_s;
                regWrData_r <= headData_s;
                flagZero    <= (headData_s == '0);
                flagNeg     <= headData_s[size-1];
            end
            if (push_s && isIllegal(bus.codeIn)) begin
                flagIllegal <= 1'b1;
            end
        end
    end

    assign bus.regWrEn   = regWrEn_r;
    assign bus.regWrAddr = regWrAddr_r;
    assign bus.regWrData = regWrData_r;

endmodule

// File: tb/tb_shift_writeback.sv
// Directed-vector bench for shift_writeback with hand-computed expectations.
module tb_shift_writeback;
    logic clk;
    logic rst;
    logic flagZero;
    logic flagNeg;
    logic flagIllegal;
    logic busy;
    int   testsRun;
    int   testsFailed;

    shift_writeback_if #(.size(8), .ADDRW(3)) bus ();

    shift_writeback #(.size(8), .ADDRW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .flagZero    (flagZero),
        .flagNeg     (flagNeg),
        .flagIllegal (flagIllegal),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] c, input logic [2:0] a);
        bus.validIn = v;
        bus.shiftIn = d;
        bus.codeIn  = c;
        bus.destIn  = a;
    endtask

    task automatic checkWrite(input string tag, input logic [2:0] a, input logic [7:0] d);
        checkVal({tag, "_en"}, 32'(bus.regWrEn), 32'd1);
        checkVal({tag, "_addr"}, 32'(bus.regWrAddr), 32'(a));
        checkVal({tag, "_data"}, 32'(bus.regWrData), 32'(d));
    endtask

    logic [7:0] expData;
    logic [2:0] expDest;
    int         pulses;

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        bus.wbStall = 1'b0;
        drive(1'b0, 8'h00, 2'b00, 3'd0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        checkVal("rst_en", 32'(bus.regWrEn), 32'd0);
        checkVal("rst_addr", 32'(bus.regWrAddr), 32'd0);
        checkVal("rst_data", 32'(bus.regWrData), 32'd0);
        checkVal("rst_flags", {29'd0, flagZero, flagNeg, flagIllegal}, 32'd0);
        checkVal("rst_ready", 32'(bus.readyOut), 32'd1);
        checkVal("rst_busy", 32'(busy), 32'd0);

        // Two-edge latency, negative data
        drive(1'b1, 8'h81, 2'b01, 3'd5);
        tick();
        drive(1'b0, 8'h00, 2'b00, 3'd0);
        checkVal("lat_en_early", 32'(bus.regWrEn), 32'd0);
        checkVal("lat_busy", 32'(busy), 32'd1);
        tick();
        checkWrite("lat", 3'd5, 8'h81);
        checkVal("lat_neg", 32'(flagNeg), 32'd1);
        checkVal("lat_zero", 32'(flagZero), 32'd0);
        tick();
        checkVal("lat_en_pulse", 32'(bus.regWrEn), 32'd0);
        checkVal("hold_addr", 32'(bus.regWrAddr), 32'd5);
        checkVal("hold_data", 32'(bus.regWrData), 32'h81);
        checkVal("lat_idle", 32'(busy), 32'd0);

        // Zero data sets flagZero
        drive(1'b1, 8'h00, 2'b10, 3'd2);
        tick();
        drive(1'b0, 8'h00, 2'b00, 3'd0);
        tick();
        checkWrite("zero", 3'd2, 8'h00);
        checkVal("zero_fz", 32'(flagZero), 32'd1);
        checkVal("zero_fn", 32'(flagNeg), 32'd0);
        tick();

        // Stall: fill to FULL, third entry refused, drain in order
        bus.wbStall = 1'b1;
        drive(1'b1, 8'h11, 2'b00, 3'd1);
        tick();
        checkVal("stall_ready1", 32'(bus.readyOut), 32'd1);
        drive(1'b1, 8'h22, 2'b01, 3'd2);
        tick();
        checkVal("stall_ready_full", 32'(bus.readyOut), 32'd0);
        drive(1'b1, 8'h33, 2'b10, 3'd3);
        tick();
        checkVal("stall_en", 32'(bus.regWrEn), 32'd0);
        checkVal("stall_ready_held", 32'(bus.readyOut), 32'd0);
        drive(1'b0, 8'h00, 2'b00, 3'd0);
        bus.wbStall = 1'b0;
        tick();
        checkWrite("drain0", 3'd1, 8'h11);
        tick();
        checkWrite("drain1", 3'd2, 8'h22);
        tick();
        checkVal("drain_done_en", 32'(bus.regWrEn), 32'd0);
        checkVal("drain_busy", 32'(busy), 32'd0);

        // Illegal code: discarded, sticky flag
        drive(1'b1, 8'h55, 2'b11, 3'd3);
        tick();
        checkVal("ill_flag_set", 32'(flagIllegal), 32'd1);
        drive(1'b1, 8'h0F, 2'b00, 3'd4);
        tick();
        drive(1'b0, 8'h00, 2'b00, 3'd0);
        checkVal("ill_no_write", 32'(bus.regWrEn), 32'd0);
        checkVal("ill_data_kept", 32'(bus.regWrData), 32'h22);
        tick();
        checkWrite("ill_next", 3'd4, 8'h0F);
        tick();
        checkVal("ill_flag_sticky", 32'(flagIllegal), 32'd1);

        // Back-to-back stream of 10 entries
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(i * 19 + 1), 2'(i % 3), 3'(i % 8));
            tick();
            if (i > 0) begin
                expData = 8'((i - 1) * 19 + 1);
                expDest = 3'((i - 1) % 8);
                checkWrite("stream", expDest, expData);
                checkVal("stream_ready", 32'(bus.readyOut), 32'd1);
                if (bus.regWrEn === 1'b1) pulses++;
            end
        end
        drive(1'b0, 8'h00, 2'b00, 3'd0);
        tick();
        checkWrite("stream_last", 3'd1, 8'(9 * 19 + 1));
        if (bus.regWrEn === 1'b1) pulses++;
        checkVal("stream_pulses", 32'(pulses), 32'd10);
        tick();
        checkVal("stream_end_en", 32'(bus.regWrEn), 32'd0);
        checkVal("stream_end_busy", 32'(busy), 32'd0);

        // Reset while FULL and stalled with a push pending
        bus.wbStall = 1'b1;
        drive(1'b1, 8'hA0, 2'b11, 3'd6);
        tick();
        drive(1'b1, 8'hB0, 2'b00, 3'd7);
        tick();
        checkVal("prerst_full", 32'(bus.readyOut), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 8'h00, 2'b00, 3'd0);
        checkVal("rst2_en", 32'(bus.regWrEn), 32'd0);
        checkVal("rst2_addr", 32'(bus.regWrAddr), 32'd0);
        checkVal("rst2_data", 32'(bus.regWrData), 32'd0);
        checkVal("rst2_flags", {29'd0, flagZero, flagNeg, flagIllegal}, 32'd0);
        checkVal("rst2_ready", 32'(bus.readyOut), 32'd1);
        checkVal("rst2_busy", 32'(busy), 32'd0);
        bus.wbStall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkVal("rst2_nowrite", 32'(bus.regWrEn), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
